// File: rtl/maxpool5_channel_sequencer_if.sv
// Tile-in / pooled-tile-out handshake bundle for the 5x5 max-pool channel sequencer.
// The master drives tiles and out_ready; the slave is the sequencer.
interface maxpool5_channel_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 2,
    parameter int H          = 6,
    parameter int W          = 6
);
    localparam int IN_W  = H * W * D * DATA_WIDTH;
    localparam int OUT_W = (H - 4) * (W - 4) * D * DATA_WIDTH;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/maxpool5_channel_sequencer.sv
// Time-multiplexes one single-channel 5x5/stride-1 max-pool engine over the D channels of a tile.
// Optional MPSEQ_PERF_CNT_EN adds a saturating busy-cycle counter on o_perf_cycles.
module maxpool5_channel_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 2,
    parameter int H          = 6,
    parameter int W          = 6,
    parameter int ENG_LAT    = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    maxpool5_channel_sequencer_if.slave          bus,
    output logic [H*W*DATA_WIDTH-1:0]            o_eng_in,
    input  logic [(H-4)*(W-4)*DATA_WIDTH-1:0]    i_eng_out,
    output logic                                 o_busy,
    output logic [$clog2(D):0]                   o_chan_idx
`ifdef MPSEQ_PERF_CNT_EN
    ,
    output logic [31:0]                          o_perf_cycles
`endif
);
    localparam int CH_IN_W  = H * W * DATA_WIDTH;
    localparam int CH_OUT_W = (H - 4) * (W - 4) * DATA_WIDTH;
    localparam int OUT_W    = CH_OUT_W * D;
    localparam int IDX_W    = $clog2(D) + 1;
    localparam int WAIT_W   = $clog2(ENG_LAT + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_in_ready;
    logic [IDX_W-1:0]    r_chan_idx;
    logic [WAIT_W-1:0]   r_wait;
    logic [CH_IN_W-1:0]  r_tile      [D];
    logic [CH_OUT_W-1:0] r_out_slice [D];
    logic [CH_IN_W-1:0]  w_in_slice  [D];
    wire  [OUT_W-1:0]    w_out_flat;

    logic w_accept;
    logic w_out_fire;
    logic w_wait_done;
    logic w_chan_last;

    assign w_accept    = bus.in_valid & r_in_ready;
    assign w_out_fire  = bus.out_ready & (r_state == S_DONE);
    assign w_wait_done = (r_wait == WAIT_W'(ENG_LAT));
    assign w_chan_last = (r_chan_idx == IDX_W'(D - 1));

    // Channel 0 sits at the MSB end of both the tile and the pooled result.
    for (genvar gi = 0; gi < D; gi++) begin : g_chan
        assign w_in_slice[gi] = bus.in_data[(D-gi)*CH_IN_W-1 -: CH_IN_W];
        assign w_out_flat[(D-gi)*CH_OUT_W-1 -: CH_OUT_W] = r_out_slice[gi];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_wait_done && w_chan_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_out_fire) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_ready <= 1'b0;
            r_chan_idx <= '0;
            r_wait     <= '0;
            for (int c = 0; c < D; c++) begin
                r_tile[c]      <= '0;
                r_out_slice[c] <= '0;
            end
        end else begin
            // Registered ready: high exactly while the FSM sits in IDLE after the first edge.
            r_in_ready <= (w_state_next == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        for (int c = 0; c < D; c++) begin
                            r_tile[c]      <= w_in_slice[c];
                            r_out_slice[c] <= '0;
                        end
                        r_chan_idx <= '0;
                        r_wait     <= '0;
                    end
                end
                S_RUN: begin
                    if (w_wait_done) begin
                        for (int c = 0; c < D; c++) begin
                            if (r_chan_idx == IDX_W'(c)) begin
                                r_out_slice[c] <= i_eng_out;
                            end
                        end
                        if (!w_chan_last) begin
                            r_chan_idx <= r_chan_idx + IDX_W'(1);
                            r_wait     <= '0;
                        end
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outside RUN the engine sees channel 0 so its input never floats.
    always_comb begin
        o_eng_in = r_tile[0];
        if (r_state == S_RUN) begin
            for (int c = 0; c < D; c++) begin
                if (r_chan_idx == IDX_W'(c)) begin
                    o_eng_in = r_tile[c];
                end
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_data  = w_out_flat;
    assign o_busy        = (r_state != S_IDLE);
    assign o_chan_idx    = r_chan_idx;

`ifdef MPSEQ_PERF_CNT_EN
    logic [31:0] r_perf_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_cycles <= '0;
        end else if (w_accept) begin
            r_perf_cycles <= '0;
        end else if ((r_state != S_IDLE) && (r_perf_cycles != 32'hFFFF_FFFF)) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
        end
    end

    assign o_perf_cycles = r_perf_cycles;
`endif

endmodule

// File: tb/tb_maxpool5_channel_sequencer.sv
// Randomized self-checking bench for maxpool5_channel_sequencer (D=2, 6x6, engine latency 3).
// A behavioural engine and a timeline-based tile model predict every output each cycle.
module tb_maxpool5_channel_sequencer;
    localparam int DW    = 16;
    localparam int D     = 2;
    localparam int H     = 6;
    localparam int W     = 6;
    localparam int L     = 3;
    localparam int OH    = H - 4;
    localparam int OW    = W - 4;
    localparam int CI    = H * W * DW;
    localparam int CO    = OH * OW * DW;
    localparam int IN_W  = CI * D;
    localparam int OUT_W = CO * D;
    localparam int IDX_W = $clog2(D) + 1;
    localparam int PER   = D * (L + 1);

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    maxpool5_channel_sequencer_if #(.DATA_WIDTH(DW), .D(D), .H(H), .W(W)) bus ();

    logic [CI-1:0]    eng_in;
    logic [CO-1:0]    eng_out;
    logic             busy;
    logic [IDX_W-1:0] chan_idx;
`ifdef MPSEQ_PERF_CNT_EN
    logic [31:0]      perf;
`endif

    maxpool5_channel_sequencer #(
        .DATA_WIDTH(DW), .D(D), .H(H), .W(W), .ENG_LAT(L)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .o_eng_in     (eng_in),
        .i_eng_out    (eng_out),
        .o_busy       (busy),
        .o_chan_idx   (chan_idx)
`ifdef MPSEQ_PERF_CNT_EN
        ,
        .o_perf_cycles(perf)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d, got no event want event", name, cyc);
    endtask

    // 5x5 window max over one channel; pixel 0 at the MSB end, row-major.
    function automatic logic [CO-1:0] pool_ch(input logic [CI-1:0] s);
        logic [CO-1:0] o;
        logic [DW-1:0] m;
        logic [DW-1:0] p;
        o = '0;
        for (int r = 0; r < OH; r++) begin
            for (int c = 0; c < OW; c++) begin
                m = '0;
                for (int i = 0; i < 5; i++) begin
                    for (int j = 0; j < 5; j++) begin
                        p = s[CI-1-((r+i)*W+c+j)*DW -: DW];
                        if (p > m) m = p;
                    end
                end
                o[CO-1-(r*OW+c)*DW -: DW] = m;
            end
        end
        return o;
    endfunction

    function automatic logic [CI-1:0] ch_of(input logic [IN_W-1:0] t, input int c);
        return t[IN_W-1-c*CI -: CI];
    endfunction

    function automatic logic [OUT_W-1:0] pool_tile(input logic [IN_W-1:0] t);
        logic [OUT_W-1:0] o;
        o = '0;
        for (int c = 0; c < D; c++) o[OUT_W-1-c*CO -: CO] = pool_ch(ch_of(t, c));
        return o;
    endfunction

    function automatic logic [IN_W-1:0] rand_tile();
        logic [IN_W-1:0] t;
        for (int i = 0; i < IN_W / 32; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    // Behavioural engine: combinational pool followed by L pipeline stages.
    generate
        if (L == 0) begin : g_eng_comb
            assign eng_out = pool_ch(eng_in);
        end else begin : g_eng_pipe
            logic [CO-1:0] pipe [L];
            always @(posedge clk) begin
                pipe[0] <= pool_ch(eng_in);
                for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
            end
            assign eng_out = pipe[L-1];
        end
    endgenerate

    // Tile-level model: accept edge k, result visible from edge k+PER, released on out_ready.
    bit               m_active = 1'b0;
    bit               m_rdy    = 1'b0;
    int               m_k      = 0;
    int               m_hs     = 0;
    logic [IN_W-1:0]  m_tile   = '0;
    logic [OUT_W-1:0] m_exp    = '0;
    logic [31:0]      m_perf   = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_rdy    <= 1'b0;
            m_tile   <= '0;
            m_perf   <= '0;
        end else if (!m_active) begin
            if (m_rdy && bus.in_valid) begin
                m_active <= 1'b1;
                m_k      <= cyc + 1;
                m_tile   <= bus.in_data;
                m_exp    <= pool_tile(bus.in_data);
                m_perf   <= '0;
                m_rdy    <= 1'b0;
            end else begin
                m_rdy <= 1'b1;
            end
        end else begin
            if (m_perf != 32'hFFFF_FFFF) m_perf <= m_perf + 32'd1;
            if ((cyc + 1 - m_k) > PER && bus.out_ready) begin
                m_active <= 1'b0;
                m_rdy    <= 1'b1;
                m_hs     <= cyc + 1;
            end
        end
    end

    always @(negedge clk) begin : compare
        int d;
        if (reset) begin
            check("rst_in_ready",  576'(bus.in_ready),  576'(0));
            check("rst_out_valid", 576'(bus.out_valid), 576'(0));
            check("rst_out_data",  576'(bus.out_data),  576'(0));
            check("rst_busy",      576'(busy),          576'(0));
            check("rst_chan_idx",  576'(chan_idx),      576'(0));
        end else begin
            check("in_ready", 576'(bus.in_ready), 576'(m_active ? 1'b0 : m_rdy));
            if (!m_active) begin
                check("idle_out_valid", 576'(bus.out_valid), 576'(0));
                check("idle_busy",      576'(busy),          576'(0));
                check("idle_eng_in",    576'(eng_in),        576'(ch_of(m_tile, 0)));
            end else begin
                d = cyc - m_k;
                check("busy", 576'(busy), 576'(1));
                if (d < PER) begin
                    check("run_out_valid", 576'(bus.out_valid), 576'(0));
                    check("run_chan_idx",  576'(chan_idx),      576'(d / (L + 1)));
                    check("run_eng_in",    576'(eng_in),        576'(ch_of(m_tile, d / (L + 1))));
                end else begin
                    check("done_out_valid", 576'(bus.out_valid), 576'(1));
                    check("done_out_data",  576'(bus.out_data),  576'(m_exp));
                    check("done_chan_idx",  576'(chan_idx),      576'(D - 1));
                    check("done_eng_in",    576'(eng_in),        576'(ch_of(m_tile, 0)));
                end
            end
`ifdef MPSEQ_PERF_CNT_EN
            check("perf_cycles", 576'(perf), 576'(m_perf));
`endif
        end
    end

    task automatic send(input logic [IN_W-1:0] t, output int acc);
        @(negedge clk);
        bus.in_data  = t;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (bus.in_ready) begin
                acc = cyc + 1;
                @(negedge clk);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        timeout("send_accept");
        bus.in_valid = 1'b0;
        acc = -1;
    endtask

    task automatic wait_valid(output int at);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                at = cyc;
                return;
            end
        end
        timeout("wait_out_valid");
        at = -1;
    endtask

    logic [IN_W-1:0]  ramp;
    logic [OUT_W-1:0] ramp_exp;
    int acc;
    int at;
    int prev;
    bit got;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 576'(bus.in_ready), 576'(1));

        // Ramp tile: ch0 = 0..35, ch1 = 35-i.
        for (int i = 0; i < H * W; i++) begin
            ramp[IN_W-1-i*DW -: DW]       = DW'(i);
            ramp[IN_W-1-(H*W+i)*DW -: DW] = DW'(H * W - 1 - i);
        end
        ramp_exp = {16'd28, 16'd29, 16'd34, 16'd35, 16'd35, 16'd34, 16'd29, 16'd28};
        send(ramp, acc);
        wait_valid(at);
        check("ramp_latency", 576'(at - acc), 576'(8));
        check("ramp_data", 576'(bus.out_data), 576'(ramp_exp));
        @(negedge clk);
`ifdef MPSEQ_PERF_CNT_EN
        check("perf_at_handshake", 576'(perf), 576'(9));
`endif

        // Output stall: held result, ignored in_valid pulses.
        bus.out_ready = 1'b0;
        send(rand_tile(), acc);
        wait_valid(at);
        repeat (10) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = rand_tile();
            check("stall_in_ready", 576'(bus.in_ready), 576'(0));
            check("stall_out_valid", 576'(bus.out_valid), 576'(1));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);

        // Reset while channel 1 is in flight.
        send(rand_tile(), acc);
        while (cyc < acc + 5) @(negedge clk);
        check("pre_reset_chan_idx", 576'(chan_idx), 576'(1));
        #2 reset = 1'b1;
        #1;
        check("abort_out_valid", 576'(bus.out_valid), 576'(0));
        check("abort_busy",      576'(busy),          576'(0));
        check("abort_out_data",  576'(bus.out_data),  576'(0));
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        send({(IN_W/DW){16'h7FFF}}, acc);
        wait_valid(at);
        check("sat_data", 576'(bus.out_data), 576'({(OUT_W/DW){16'h7FFF}}));
        @(negedge clk);

        // Back-to-back tiles with in_valid held high.
        prev = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = rand_tile();
            got = 1'b0;
            for (int n = 0; n < 100 && !got; n++) begin
                if (bus.in_ready) got = 1'b1;
                else @(negedge clk);
            end
            if (!got) begin
                timeout("b2b_accept");
            end else begin
                acc = cyc + 1;
                if (i > 0) begin
                    check("b2b_gap_after_hs", 576'(acc - m_hs), 576'(1));
                    check("b2b_issue_interval", 576'(acc - prev), 576'(PER + 2));
                end
                prev = acc;
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
        wait_valid(at);
        @(negedge clk);

        // Random traffic and back-pressure.
        repeat (600) begin
            @(negedge clk);
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = rand_tile();
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
